// File: rtl/reorder_buffer_pkg.sv
// Shared types and constants for the reorder buffer slice.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package reorder_buffer_pkg;

    // Default tag width; DEPTH = 2**W - 1 because tag 0 means "value lives in the RegFile".
    localparam int ROB_ENTRY_WIDTH_DEF = 5;
    localparam int DR_WIDTH            = 5;
    localparam int DATA_WIDTH          = 32;
    localparam int ROBEN_NONE          = 0;

    // One ROB slot. ready only has meaning while valid is set.
    typedef struct packed {
        logic                  valid;
        logic                  ready;
        logic [DR_WIDTH-1:0]   dr;
        logic [DATA_WIDTH-1:0] data;
    } rob_entry_t;

endpackage

// File: rtl/reorder_buffer_entry_array.sv
// ROB slot storage: allocation write, CDB result capture, commit clear, head view and two operand read ports.
// Latency: writes visible next cycle; read ports combinational (same-cycle CDB bypass under ROB_CDB_BYPASS_EN).
// Backpressure: none; the caller guarantees alloc targets a free slot and commit targets a ready head.
//
// Ports: clk/rst (sync, active-high), flush; alloc_en/alloc_tag/alloc_dr; cdb_vld/cdb_tag/cdb_dat;
//        commit_en/head_tag with head_vld/head_rdy/head_dr/head_dat; rd_tag1/2 -> rd_rdy1/2, rd_dat1/2.
// Config macro: ROB_CDB_BYPASS_EN forwards a same-cycle CDB write to matching read ports.
module reorder_buffer_entry_array
    import reorder_buffer_pkg::*;
#(
    parameter int W = ROB_ENTRY_WIDTH_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  alloc_en,
    input  logic [W-1:0]          alloc_tag,
    input  logic [DR_WIDTH-1:0]   alloc_dr,
    input  logic                  cdb_vld,
    input  logic [W-1:0]          cdb_tag,
    input  logic [DATA_WIDTH-1:0] cdb_dat,
    input  logic                  commit_en,
    input  logic [W-1:0]          head_tag,
    output logic                  head_vld,
    output logic                  head_rdy,
    output logic [DR_WIDTH-1:0]   head_dr,
    output logic [DATA_WIDTH-1:0] head_dat,
    input  logic [W-1:0]          rd_tag1,
    input  logic [W-1:0]          rd_tag2,
    output logic                  rd_rdy1,
    output logic                  rd_rdy2,
    output logic [DATA_WIDTH-1:0] rd_dat1,
    output logic [DATA_WIDTH-1:0] rd_dat2
);

    // Slot 0 exists only so a W-bit tag indexes the array directly; it is never allocated.
    localparam int ENTRIES = 1 << W;

    rob_entry_t entry_q [ENTRIES];
    logic       cdb_hit;

    // Results for tag 0 or for slots that are not in flight are dropped.
    assign cdb_hit = cdb_vld && (cdb_tag != '0) && entry_q[cdb_tag].valid;

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            for (int i = 0; i < ENTRIES; i++) begin
                entry_q[i].valid <= 1'b0;
                entry_q[i].ready <= 1'b0;
            end
        end else begin
            if (cdb_hit) begin
                entry_q[cdb_tag].ready <= 1'b1;
                entry_q[cdb_tag].data  <= cdb_dat;
            end
            if (commit_en) begin
                entry_q[head_tag].valid <= 1'b0;
                entry_q[head_tag].ready <= 1'b0;
            end
            // Allocation always targets a free slot, so it cannot collide with the commit or CDB slot.
            if (alloc_en) begin
                entry_q[alloc_tag].valid <= 1'b1;
                entry_q[alloc_tag].ready <= 1'b0;
                entry_q[alloc_tag].dr    <= alloc_dr;
            end
        end
    end

    assign head_vld = entry_q[head_tag].valid;
    assign head_rdy = entry_q[head_tag].ready;
    assign head_dr  = entry_q[head_tag].dr;
    assign head_dat = entry_q[head_tag].data;

    // Returns {ready, data}; data is forced to 0 whenever ready is low.
    function automatic logic [DATA_WIDTH:0] lookup(input logic [W-1:0] tag);
        logic [DATA_WIDTH:0] r;
        r = '0;
        if ((tag != '0) && entry_q[tag].valid && entry_q[tag].ready) begin
            r = {1'b1, entry_q[tag].data};
        end
`ifdef ROB_CDB_BYPASS_EN
        // A flushed cycle performs no CDB write, so nothing is forwarded then.
        if (cdb_hit && !flush && (cdb_tag == tag)) begin
            r = {1'b1, cdb_dat};
        end
`endif
        return r;
    endfunction

    assign {rd_rdy1, rd_dat1} = lookup(rd_tag1);
    assign {rd_rdy2, rd_dat2} = lookup(rd_tag2);

endmodule

// File: rtl/reorder_buffer.sv
// Reorder buffer: allocates tags at issue, captures CDB results, retires the head in program order.
// Latency: alloc tag combinational; CDB write -> WP1_Wen high 2 cycles minimum; commit outputs registered.
// Backpressure: ALLOC_Ready drops when all DEPTH slots are in flight; no input stalls otherwise.
//
// Ports: clk, rst (sync, active-high); ALLOC_* issue handshake; WP1_*_IQ tag-write to RegFile;
//        CDB_* result broadcast; FLUSH; RP1_* two operand read ports; WP1_* registered commit port.
// Config macro: ROB_CDB_BYPASS_EN (see reorder_buffer_entry_array).
module reorder_buffer
    import reorder_buffer_pkg::*;
#(
    parameter int ROB_Entry_WIDTH = ROB_ENTRY_WIDTH_DEF
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       ALLOC_Valid,
    input  logic [DR_WIDTH-1:0]        ALLOC_DRindex,
    output logic                       ALLOC_Ready,
    output logic [ROB_Entry_WIDTH-1:0] ALLOC_ROBEN,
    output logic                       WP1_Wen_IQ,
    output logic [ROB_Entry_WIDTH-1:0] WP1_ROBEN_IQ,
    output logic [DR_WIDTH-1:0]        WP1_DRindex_IQ,
    input  logic                       CDB_Valid,
    input  logic [ROB_Entry_WIDTH-1:0] CDB_ROBEN,
    input  logic [DATA_WIDTH-1:0]      CDB_Data,
    input  logic                       FLUSH,
    input  logic [ROB_Entry_WIDTH-1:0] RP1_ROBEN1,
    input  logic [ROB_Entry_WIDTH-1:0] RP1_ROBEN2,
    output logic                       RP1_Ready1,
    output logic                       RP1_Ready2,
    output logic [DATA_WIDTH-1:0]      RP1_Data1,
    output logic [DATA_WIDTH-1:0]      RP1_Data2,
    output logic                       WP1_Wen,
    output logic [ROB_Entry_WIDTH-1:0] WP1_ROBEN,
    output logic [DR_WIDTH-1:0]        WP1_DRindex,
    output logic [DATA_WIDTH-1:0]      WP1_Data
);

    localparam int                 W         = ROB_Entry_WIDTH;
    localparam int                 DEPTH     = (1 << W) - 1;
    // DEPTH is all-ones in W bits: it is both the last valid tag and the full count.
    localparam logic [W-1:0]       LAST_TAG  = DEPTH[W-1:0];
    localparam logic [W-1:0]       FIRST_TAG = {{(W-1){1'b0}}, 1'b1};

    logic [W-1:0]          head_q;
    logic [W-1:0]          tail_q;
    logic [W-1:0]          count_q;
    logic                  alloc_fire;
    logic                  commit_fire;
    logic                  head_vld;
    logic                  head_rdy;
    logic [DR_WIDTH-1:0]   head_dr;
    logic [DATA_WIDTH-1:0] head_dat;

    // Tags cycle 1..DEPTH, skipping 0.
    function automatic logic [W-1:0] next_ptr(input logic [W-1:0] p);
        return (p == LAST_TAG) ? FIRST_TAG : p + FIRST_TAG;
    endfunction

    // Fullness uses the registered count only, so a retiring head never frees a slot in the same cycle.
    assign ALLOC_Ready    = (count_q != LAST_TAG);
    assign ALLOC_ROBEN    = tail_q;
    assign alloc_fire     = ALLOC_Valid && ALLOC_Ready && !FLUSH;
    assign commit_fire    = head_vld && head_rdy && !FLUSH;

    assign WP1_Wen_IQ     = alloc_fire;
    assign WP1_ROBEN_IQ   = tail_q;
    assign WP1_DRindex_IQ = ALLOC_DRindex;

    always_ff @(posedge clk) begin
        if (rst || FLUSH) begin
            head_q  <= FIRST_TAG;
            tail_q  <= FIRST_TAG;
            count_q <= '0;
        end else begin
            if (alloc_fire) begin
                tail_q <= next_ptr(tail_q);
            end
            if (commit_fire) begin
                head_q <= next_ptr(head_q);
            end
            if (alloc_fire && !commit_fire) begin
                count_q <= count_q + FIRST_TAG;
            end else if (commit_fire && !alloc_fire) begin
                count_q <= count_q - FIRST_TAG;
            end
        end
    end

    // Commit port: tag/dest/data hold between commits; only the enable pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            WP1_Wen     <= 1'b0;
            WP1_ROBEN   <= '0;
            WP1_DRindex <= '0;
            WP1_Data    <= '0;
        end else if (commit_fire) begin
            // Destination 0 retires without touching the RegFile.
            WP1_Wen     <= (head_dr != '0);
            WP1_ROBEN   <= head_q;
            WP1_DRindex <= head_dr;
            WP1_Data    <= head_dat;
        end else begin
            WP1_Wen     <= 1'b0;
        end
    end

    reorder_buffer_entry_array #(
        .W (W)
    ) u_entries (
        .clk       (clk),
        .rst       (rst),
        .flush     (FLUSH),
        .alloc_en  (alloc_fire),
        .alloc_tag (tail_q),
        .alloc_dr  (ALLOC_DRindex),
        .cdb_vld   (CDB_Valid),
        .cdb_tag   (CDB_ROBEN),
        .cdb_dat   (CDB_Data),
        .commit_en (commit_fire),
        .head_tag  (head_q),
        .head_vld  (head_vld),
        .head_rdy  (head_rdy),
        .head_dr   (head_dr),
        .head_dat  (head_dat),
        .rd_tag1   (RP1_ROBEN1),
        .rd_tag2   (RP1_ROBEN2),
        .rd_rdy1   (RP1_Ready1),
        .rd_rdy2   (RP1_Ready2),
        .rd_dat1   (RP1_Data1),
        .rd_dat2   (RP1_Data2)
    );

endmodule
